// File: rtl/cart_loader_if.sv
// cart_loader_if
//   Groups the HPS download stream (ioctl_*) and the cart ROM write port
//   (cart_addr/cart_data/cart_wr) that cart_loader sits between.
//   master : the download source; drives ioctl_*, observes the ROM writes.
//   slave  : the loader; consumes ioctl_*, drives the ROM write port.
interface cart_loader_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [14:0] cart_addr;
  logic [7:0]  cart_data;
  logic        cart_wr;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    input  cart_addr, cart_data, cart_wr
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    output cart_addr, cart_data, cart_wr
  );
endinterface

// File: rtl/cart_loader.sv
// cart_loader
//   Turns an HPS cart-image download into cart ROM writes for the vectrex
//   core, builds the ROM address mask and byte count, and holds the core in
//   reset while the image is loading and for RST_HOLD cycles afterwards.
//
// Ports
//   clk_sys     system clock, all logic on its rising edge
//   reset       synchronous active-high reset
//   bus         cart_loader_if.slave: ioctl_* download in, cart_* ROM write out
//   cart_mask   ROM address mask, always 2^n-1
//   cart_size   accepted byte count, saturating at 32768
//   cart_valid  a usable image is loaded
//   hdr_ok      image header matched (always 1 in READY without the check)
//   overflow    a byte at address >= 32768 was dropped during the last load
//   core_reset  reset request to the core, high in LOAD and HOLD
//
// Build option
//   CART_HEADER_CHECK_EN  when defined, bytes 0..4 must read "g GCE"
//                         (67 20 47 43 45) for hdr_ok and cart_valid.
module cart_loader #(
  parameter int RST_HOLD = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  cart_loader_if.slave bus,
  output logic [14:0] cart_mask,
  output logic [15:0] cart_size,
  output logic        cart_valid,
  output logic        hdr_ok,
  output logic        overflow,
  output logic        core_reset
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_READY = 2'd3;

  logic [1:0]  state;
  logic        download_d;
  logic [7:0]  hold_cnt;

  logic        dl_rise;
  logic        dl_fall;
  logic        wr_take;
  logic        wr_accept;
  logic        wr_drop;
  logic        hold_done;
  logic        hdr_pass;
  logic [14:0] addr_lo;
  logic [14:0] addr_smear;
  logic [14:0] mask_base;
  logic [15:0] size_base;
  logic        ovf_base;

  // A write coincident with the download rising edge already belongs to the
  // new load, so the "base" values are the cleared ones on that cycle.
  always_comb begin
    dl_rise    = bus.ioctl_download & ~download_d;
    dl_fall    = ~bus.ioctl_download & download_d;
    wr_take    = bus.ioctl_wr & ((state == ST_LOAD) | dl_rise);
    wr_accept  = wr_take & (bus.ioctl_addr[24:15] == 10'd0);
    wr_drop    = wr_take & (bus.ioctl_addr[24:15] != 10'd0);
    hold_done  = (state == ST_HOLD) & ~dl_rise & (hold_cnt <= 8'd1);
    addr_lo    = bus.ioctl_addr[14:0];
    // Smear the highest set bit downwards
    addr_smear = addr_lo | (addr_lo >> 1);
    addr_smear = addr_smear | (addr_smear >> 2);
    addr_smear = addr_smear | (addr_smear >> 4);
    addr_smear = addr_smear | (addr_smear >> 8);
    mask_base  = dl_rise ? 15'd0 : cart_mask;
    size_base  = dl_rise ? 16'd0 : cart_size;
    ovf_base   = dl_rise ? 1'b0  : overflow;
  end

  assign core_reset = (state == ST_LOAD) | (state == ST_HOLD);

  // download_d resets high so a download already in progress when reset
  // releases is not mistaken for a fresh rising edge.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state         <= ST_IDLE;
      download_d    <= 1'b1;
      hold_cnt      <= 8'd0;
      bus.cart_wr   <= 1'b0;
      bus.cart_addr <= 15'd0;
      bus.cart_data <= 8'd0;
      cart_mask     <= 15'd0;
      cart_size     <= 16'd0;
      overflow      <= 1'b0;
      cart_valid    <= 1'b0;
    end else begin
      download_d  <= bus.ioctl_download;
      bus.cart_wr <= wr_accept;
      if (wr_accept) begin
        bus.cart_addr <= addr_lo;
        bus.cart_data <= bus.ioctl_dout;
      end
      cart_mask <= wr_accept ? (mask_base | addr_smear) : mask_base;
      cart_size <= (wr_accept && size_base != 16'h8000) ? size_base + 16'd1 : size_base;
      overflow  <= ovf_base | wr_drop;

      case (state)
        ST_IDLE, ST_READY: begin
          if (dl_rise) begin
            state      <= ST_LOAD;
            cart_valid <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (dl_fall) begin
            state    <= ST_HOLD;
            hold_cnt <= 8'(RST_HOLD);
          end
        end
        ST_HOLD: begin
          if (dl_rise) begin
            state      <= ST_LOAD;
            cart_valid <= 1'b0;
          end else if (hold_done) begin
            state      <= ST_READY;
            hold_cnt   <= 8'd0;
            cart_valid <= (cart_size != 16'd0) & hdr_pass;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CART_HEADER_CHECK_EN
  logic [4:0] hdr_seen;
  logic [4:0] hdr_match;
  logic       hdr_hit;
  logic [7:0] hdr_expect;

  always_comb begin
    hdr_hit  = wr_accept & (bus.ioctl_addr[24:3] == 22'd0) & (bus.ioctl_addr[2:0] < 3'd5);
    hdr_pass = &(hdr_seen & hdr_match);
    case (bus.ioctl_addr[2:0])
      3'd0:    hdr_expect = 8'h67;
      3'd1:    hdr_expect = 8'h20;
      3'd2:    hdr_expect = 8'h47;
      3'd3:    hdr_expect = 8'h43;
      default: hdr_expect = 8'h45;
    endcase
  end

  // The last write to a header address decides whether that byte matches.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hdr_seen  <= 5'd0;
      hdr_match <= 5'd0;
      hdr_ok    <= 1'b0;
    end else begin
      if (dl_rise) begin
        hdr_seen  <= 5'd0;
        hdr_match <= 5'd0;
        hdr_ok    <= 1'b0;
      end
      if (hdr_hit) begin
        hdr_seen[bus.ioctl_addr[2:0]]  <= 1'b1;
        hdr_match[bus.ioctl_addr[2:0]] <= (bus.ioctl_dout == hdr_expect);
      end
      if (hold_done) begin
        hdr_ok <= hdr_pass;
      end
    end
  end
`else
  assign hdr_pass = 1'b1;
  assign hdr_ok   = (state == ST_READY);
`endif

endmodule

// File: tb/tb_cart_loader.sv
// tb_cart_loader
//   Directed bench for cart_loader: reset, a full 8 KiB load, single writes
//   at mask/overflow boundaries, empty download, coincident edges, restart
//   during HOLD, size saturation, header match and reset mid-load.
//   Expectations adapt to CART_HEADER_CHECK_EN so either build can be run.
module tb_cart_loader;
  localparam int RST_HOLD = 16;
`ifdef CART_HEADER_CHECK_EN
  localparam logic HDR_EN = 1'b1;
`else
  localparam logic HDR_EN = 1'b0;
`endif
  // hdr_ok / cart_valid expected for a non-empty image with a bad header
  localparam logic BAD_HDR_VALID = ~HDR_EN;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [14:0] cart_mask;
  logic [15:0] cart_size;
  logic        cart_valid;
  logic        hdr_ok;
  logic        overflow;
  logic        core_reset;

  int checks = 0;
  int errors = 0;

  logic [7:0] hdr_bytes [5] = '{8'h67, 8'h20, 8'h47, 8'h43, 8'h45};

  cart_loader_if bus ();

  cart_loader #(.RST_HOLD(RST_HOLD)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .bus        (bus),
    .cart_mask  (cart_mask),
    .cart_size  (cart_size),
    .cart_valid (cart_valid),
    .hdr_ok     (hdr_ok),
    .overflow   (overflow),
    .core_reset (core_reset)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [7:0] img_byte(int i);
    if (i < 5) return hdr_bytes[i];
    return 8'(i) ^ 8'hA5;
  endfunction

  // Counts post-edge samples with core_reset high, starting at the edge that
  // sees ioctl_download low; bounded so a stuck core_reset cannot hang.
  task automatic hold_count(output int n);
    n = 0;
    tick();
    while (core_reset === 1'b1 && n < 2000) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = 25'd0;
    bus.ioctl_dout = 8'd0;
    tick();
    tick();
    checks++;
    if ({bus.cart_wr, cart_mask, cart_size, cart_valid, hdr_ok, overflow, core_reset} !== 36'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got wr=%b mask=%h size=%h valid=%b hdr=%b ovf=%b crst=%b, expected all 0",
               bus.cart_wr, cart_mask, cart_size, cart_valid, hdr_ok, overflow, core_reset);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({core_reset, hdr_ok} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got crst=%b hdr=%b, expected 0 0", core_reset, hdr_ok);
    end
  endtask

  task automatic test_sequential;
    int good = 0;
    int bad = 0;
    int n;
    bus.ioctl_download = 1'b1;
    tick();
    checks++;
    if ({core_reset, hdr_ok} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL load_entry: got crst=%b hdr=%b, expected 1 0", core_reset, hdr_ok);
    end
    for (int i = 0; i < 8192; i++) begin
      bus.ioctl_wr = 1'b1;
      bus.ioctl_addr = 25'(i);
      bus.ioctl_dout = img_byte(i);
      tick();
      bus.ioctl_wr = 1'b0;
      if (bus.cart_wr === 1'b1 && bus.cart_addr === 15'(i) && bus.cart_data === img_byte(i)) good++;
      tick();
      if (bus.cart_wr !== 1'b0) bad++;
    end
    checks++;
    if (good != 8192) begin
      errors++;
      $display("[TB] FAIL seq_pulses: got %0d correct cart_wr pulses, expected 8192", good);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL seq_pulse_width: got %0d extra cart_wr cycles, expected 0", bad);
    end
    checks++;
    if ({cart_mask, cart_size} !== {15'h1FFF, 16'd8192}) begin
      errors++;
      $display("[TB] FAIL seq_mask_size: got mask=%h size=%0d, expected 1fff 8192", cart_mask, cart_size);
    end
    bus.ioctl_download = 1'b0;
    hold_count(n);
    checks++;
    if (n != RST_HOLD) begin
      errors++;
      $display("[TB] FAIL seq_hold_len: got %0d cycles, expected %0d", n, RST_HOLD);
    end
    checks++;
    if ({cart_valid, hdr_ok, overflow, cart_mask} !== {1'b1, 1'b1, 1'b0, 15'h1FFF}) begin
      errors++;
      $display("[TB] FAIL seq_ready: got valid=%b hdr=%b ovf=%b mask=%h, expected 1 1 0 1fff",
               cart_valid, hdr_ok, overflow, cart_mask);
    end
  endtask

  task automatic test_single_writes;
    int n;
    bus.ioctl_download = 1'b1;
    tick();
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h0100; bus.ioctl_dout = 8'h11;
    tick();
    bus.ioctl_wr = 1'b0;
    checks++;
    if ({bus.cart_wr, bus.cart_addr, bus.cart_data, cart_mask, cart_size} !==
        {1'b1, 15'h0100, 8'h11, 15'h01FF, 16'd1}) begin
      errors++;
      $display("[TB] FAIL write_0100: got wr=%b addr=%h data=%h mask=%h size=%0d, expected 1 0100 11 01ff 1",
               bus.cart_wr, bus.cart_addr, bus.cart_data, cart_mask, cart_size);
    end
    tick();
    checks++;
    if (bus.cart_wr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wr_one_cycle: got cart_wr=%b, expected 0", bus.cart_wr);
    end
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h7FFF; bus.ioctl_dout = 8'h22;
    tick();
    bus.ioctl_wr = 1'b0;
    checks++;
    if ({bus.cart_wr, cart_mask, cart_size} !== {1'b1, 15'h7FFF, 16'd2}) begin
      errors++;
      $display("[TB] FAIL write_7fff: got wr=%b mask=%h size=%0d, expected 1 7fff 2", bus.cart_wr, cart_mask, cart_size);
    end
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h8000; bus.ioctl_dout = 8'h33;
    tick();
    bus.ioctl_wr = 1'b0;
    checks++;
    if ({bus.cart_wr, overflow, cart_mask, cart_size} !== {1'b0, 1'b1, 15'h7FFF, 16'd2}) begin
      errors++;
      $display("[TB] FAIL write_8000: got wr=%b ovf=%b mask=%h size=%0d, expected 0 1 7fff 2",
               bus.cart_wr, overflow, cart_mask, cart_size);
    end
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h0000; bus.ioctl_dout = 8'h44;
    tick();
    bus.ioctl_wr = 1'b0;
    checks++;
    if ({bus.cart_wr, bus.cart_addr, cart_mask, cart_size} !== {1'b1, 15'h0000, 15'h7FFF, 16'd3}) begin
      errors++;
      $display("[TB] FAIL write_0000: got wr=%b addr=%h mask=%h size=%0d, expected 1 0000 7fff 3",
               bus.cart_wr, bus.cart_addr, cart_mask, cart_size);
    end
    bus.ioctl_download = 1'b0;
    hold_count(n);
    checks++;
    if ({cart_valid, overflow} !== {BAD_HDR_VALID, 1'b1}) begin
      errors++;
      $display("[TB] FAIL single_ready: got valid=%b ovf=%b, expected %b 1", cart_valid, overflow, BAD_HDR_VALID);
    end
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h0005; bus.ioctl_dout = 8'h55;
    tick();
    bus.ioctl_wr = 1'b0;
    checks++;
    if ({bus.cart_wr, cart_size, core_reset} !== {1'b0, 16'd3, 1'b0}) begin
      errors++;
      $display("[TB] FAIL wr_outside_load: got wr=%b size=%0d crst=%b, expected 0 3 0", bus.cart_wr, cart_size, core_reset);
    end
  endtask

  task automatic test_empty;
    int n = 0;
    int m;
    bus.ioctl_download = 1'b1;
    repeat (3) begin
      tick();
      if (core_reset === 1'b1) n++;
    end
    bus.ioctl_download = 1'b0;
    hold_count(m);
    checks++;
    if (n + m != 3 + RST_HOLD) begin
      errors++;
      $display("[TB] FAIL empty_hold_len: got %0d cycles, expected %0d", n + m, 3 + RST_HOLD);
    end
    checks++;
    if ({cart_valid, cart_mask, cart_size, overflow} !== 33'd0) begin
      errors++;
      $display("[TB] FAIL empty_ready: got valid=%b mask=%h size=%0d ovf=%b, expected all 0",
               cart_valid, cart_mask, cart_size, overflow);
    end
  endtask

  task automatic test_coincident_edges;
    int n;
    bus.ioctl_download = 1'b1;
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h0003; bus.ioctl_dout = 8'h77;
    tick();
    bus.ioctl_wr = 1'b0;
    checks++;
    if ({bus.cart_wr, cart_size, cart_mask} !== {1'b1, 16'd1, 15'h0003}) begin
      errors++;
      $display("[TB] FAIL wr_on_rise: got wr=%b size=%0d mask=%h, expected 1 1 0003", bus.cart_wr, cart_size, cart_mask);
    end
    tick();
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h0010; bus.ioctl_dout = 8'h88;
    tick();
    bus.ioctl_wr = 1'b0;
    checks++;
    if ({bus.cart_wr, bus.cart_addr, cart_size, cart_mask} !== {1'b1, 15'h0010, 16'd2, 15'h001F}) begin
      errors++;
      $display("[TB] FAIL wr_on_fall: got wr=%b addr=%h size=%0d mask=%h, expected 1 0010 2 001f",
               bus.cart_wr, bus.cart_addr, cart_size, cart_mask);
    end
    hold_count(n);
  endtask

  task automatic test_restart;
    int dropped = 0;
    int n;
    bus.ioctl_download = 1'b1;
    tick();
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h0040; bus.ioctl_dout = 8'h01;
    tick();
    bus.ioctl_wr = 1'b0;
    bus.ioctl_download = 1'b0;
    repeat (3) begin
      tick();
      if (core_reset !== 1'b1) dropped++;
    end
    bus.ioctl_download = 1'b1;
    tick();
    checks++;
    if ({core_reset, cart_mask, cart_size} !== {1'b1, 15'd0, 16'd0}) begin
      errors++;
      $display("[TB] FAIL restart_clear: got crst=%b mask=%h size=%0d, expected 1 0000 0", core_reset, cart_mask, cart_size);
    end
    repeat (RST_HOLD + 4) begin
      tick();
      if (core_reset !== 1'b1) dropped++;
    end
    checks++;
    if (dropped != 0) begin
      errors++;
      $display("[TB] FAIL restart_core_reset: got %0d low cycles, expected 0", dropped);
    end
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h0002; bus.ioctl_dout = 8'h02;
    tick();
    bus.ioctl_wr = 1'b0;
    checks++;
    if ({bus.cart_wr, cart_size, cart_mask} !== {1'b1, 16'd1, 15'h0003}) begin
      errors++;
      $display("[TB] FAIL restart_in_load: got wr=%b size=%0d mask=%h, expected 1 1 0003", bus.cart_wr, cart_size, cart_mask);
    end
    bus.ioctl_download = 1'b0;
    hold_count(n);
  endtask

  task automatic test_saturation;
    logic [15:0] size_at_32767 = 16'd0;
    int n;
    bus.ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 32768; i++) begin
      bus.ioctl_wr = 1'b1;
      bus.ioctl_addr = 25'(i);
      bus.ioctl_dout = img_byte(i);
      tick();
      if (i == 32766) size_at_32767 = cart_size;
    end
    checks++;
    if ({size_at_32767, cart_size} !== {16'd32767, 16'd32768}) begin
      errors++;
      $display("[TB] FAIL size_boundary: got %0d then %0d, expected 32767 then 32768", size_at_32767, cart_size);
    end
    bus.ioctl_addr = 25'h1234;
    bus.ioctl_dout = 8'h99;
    tick();
    bus.ioctl_wr = 1'b0;
    checks++;
    if ({bus.cart_wr, cart_size, cart_mask} !== {1'b1, 16'd32768, 15'h7FFF}) begin
      errors++;
      $display("[TB] FAIL size_saturate: got wr=%b size=%0d mask=%h, expected 1 32768 7fff", bus.cart_wr, cart_size, cart_mask);
    end
    bus.ioctl_download = 1'b0;
    hold_count(n);
    checks++;
    if (cart_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sat_valid: got %b, expected 1", cart_valid);
    end
  endtask

  task automatic test_header;
    int n;
    for (int pass = 0; pass < 2; pass++) begin
      bus.ioctl_download = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
        bus.ioctl_wr = 1'b1;
        bus.ioctl_addr = 25'(i);
        bus.ioctl_dout = (pass == 1 && i == 2) ? 8'h48 : img_byte(i);
        tick();
      end
      bus.ioctl_wr = 1'b0;
      bus.ioctl_download = 1'b0;
      hold_count(n);
      checks++;
      if (pass == 0 && {hdr_ok, cart_valid} !== 2'b11) begin
        errors++;
        $display("[TB] FAIL header_good: got hdr=%b valid=%b, expected 1 1", hdr_ok, cart_valid);
      end else if (pass == 1 && {hdr_ok, cart_valid} !== {BAD_HDR_VALID, BAD_HDR_VALID}) begin
        errors++;
        $display("[TB] FAIL header_bad: got hdr=%b valid=%b, expected %b %b", hdr_ok, cart_valid, BAD_HDR_VALID, BAD_HDR_VALID);
      end
    end
  endtask

  task automatic test_reset_midload;
    int seen_wr = 0;
    int seen_crst = 0;
    int n;
    bus.ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) begin
      bus.ioctl_wr = 1'b1;
      bus.ioctl_addr = 25'(i);
      bus.ioctl_dout = img_byte(i);
      tick();
    end
    reset = 1'b1;
    bus.ioctl_addr = 25'd200;
    tick();
    checks++;
    if ({bus.cart_wr, cart_mask, cart_size, cart_valid, hdr_ok, overflow, core_reset} !== 36'd0) begin
      errors++;
      $display("[TB] FAIL midload_reset: got wr=%b mask=%h size=%h valid=%b hdr=%b ovf=%b crst=%b, expected all 0",
               bus.cart_wr, cart_mask, cart_size, cart_valid, hdr_ok, overflow, core_reset);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.ioctl_addr = 25'(300 + i);
      tick();
      if (bus.cart_wr !== 1'b0) seen_wr++;
      if (core_reset !== 1'b0) seen_crst++;
    end
    checks++;
    if ({seen_wr, seen_crst} !== {32'd0, 32'd0}) begin
      errors++;
      $display("[TB] FAIL no_load_after_reset: got %0d cart_wr and %0d core_reset cycles, expected 0 0", seen_wr, seen_crst);
    end
    bus.ioctl_wr = 1'b0;
    bus.ioctl_download = 1'b0;
    tick();
    bus.ioctl_download = 1'b1;
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h0007; bus.ioctl_dout = 8'h5A;
    tick();
    bus.ioctl_wr = 1'b0;
    checks++;
    if ({bus.cart_wr, cart_size, core_reset} !== {1'b1, 16'd1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL fresh_rise: got wr=%b size=%0d crst=%b, expected 1 1 1", bus.cart_wr, cart_size, core_reset);
    end
    bus.ioctl_download = 1'b0;
    hold_count(n);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_single_writes();
    test_empty();
    test_coincident_edges();
    test_restart();
    test_saturation();
    test_header();
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cart_loader.md
CART_LOADER -- requirements
Module: cart_loader

Interface
REQ-001 Parameter RST_HOLD, default 16: cycles core_reset stays high after a download ends; legal range 1..255.
REQ-002 clock  in  1  system clock (clk_sys); all logic on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ioctl_download  in  1  high while the HPS streams a cart image.
REQ-005 ioctl_wr  in  1  one-cycle pulse; the byte on ioctl_dout is valid at ioctl_addr.
REQ-006 ioctl_addr  in  25  byte address of the current image byte.
REQ-007 ioctl_dout  in  8  image byte.
REQ-008 cart_addr  out  15  cart ROM write address.
REQ-009 cart_data  out  8  cart ROM write data.
REQ-010 cart_wr  out  1  one-cycle cart ROM write strobe.
REQ-011 cart_mask  out  15  cart address mask, always of the form 2^n-1.
REQ-012 cart_size  out  16  count of accepted bytes, saturating at 32768.
REQ-013 cart_valid  out  1  a usable image is loaded.
REQ-014 hdr_ok  out  1  the image header matched (see Configuration).
REQ-015 overflow  out  1  a byte at address >= 32768 was dropped during the last load.
REQ-016 core_reset  out  1  reset request to the vectrex core.

Function
REQ-017 FSM states: IDLE, LOAD, HOLD, READY; the encoding is not exposed.
REQ-018 IDLE or READY -> LOAD on the rising edge of ioctl_download; entry clears cart_mask, cart_size, overflow, hdr_ok and cart_valid.
REQ-019 LOAD -> HOLD on the falling edge of ioctl_download; HOLD loads a down-counter with RST_HOLD.
REQ-020 HOLD -> READY when the counter reaches 0; a rising edge of ioctl_download in HOLD goes to LOAD (restart).
REQ-021 In LOAD, each ioctl_wr with ioctl_addr < 32768 produces cart_wr=1 exactly one cycle later, with cart_addr=ioctl_addr[14:0] and cart_data=ioctl_dout registered.
REQ-022 In LOAD, ioctl_wr with ioctl_addr >= 32768 produces no cart_wr, sets overflow, and leaves cart_mask and cart_size unchanged.
REQ-023 Accepted writes update cart_mask <= cart_mask | smear(addr), where smear sets every bit at or below the highest set bit of addr[14:0]. Address 0 leaves the mask unchanged.
REQ-024 cart_size increments by 1 per accepted write and saturates at 32768. Repeated addresses are counted.
REQ-025 ioctl_wr outside LOAD is ignored: no cart_wr and no state change.
REQ-026 core_reset = 1 in LOAD and HOLD, and 0 in IDLE and READY.
REQ-027 cart_valid is evaluated on HOLD->READY: 1 iff cart_size > 0 (and the Configuration condition holds). It is held until the next LOAD entry.
REQ-028 Empty download (no accepted writes): READY with cart_valid=0 and cart_mask=0.
REQ-029 ioctl_wr coincident with the download rising edge is accepted as the first LOAD byte. ioctl_wr coincident with the falling edge is still accepted.

Reset
REQ-030 reset forces IDLE, all outputs 0 (including core_reset and cart_wr), and clears the counter and header tracking.
REQ-031 reset asserted mid-LOAD aborts the load.
REQ-032 After reset releases with ioctl_download still high, no LOAD is entered until a fresh rising edge.

Configuration
REQ-033 Macro CART_HEADER_CHECK_EN.
- Defined: track the bytes at addresses 0..4 against 0x67,0x20,0x47,0x43,0x45 ("g GCE").
- hdr_ok = all five written and matched, evaluated at HOLD->READY.
- cart_valid additionally requires hdr_ok.
REQ-034 Undefined: no header logic; hdr_ok = 1 in READY and 0 otherwise; cart_valid depends only on cart_size.

Verification
REQ-035 reset, then download of 8192 sequential bytes at 0..8191 -> 8192 cart_wr pulses, each 1 cycle after ioctl_wr; cart_mask=0x1FFF; cart_size=8192; core_reset high until RST_HOLD cycles after the falling edge; cart_valid=1.
REQ-036 single write at 0x0100 -> cart_mask=0x01FF, cart_size=1; a write at 0x7FFF -> mask=0x7FFF; a write at 0x8000 -> no cart_wr, overflow=1, mask unchanged.
REQ-037 empty download of 3 cycles -> core_reset high 3+RST_HOLD cycles, then cart_valid=0, cart_mask=0.
REQ-038 download restarted 2 cycles into HOLD -> state LOAD, mask/size cleared, core_reset never drops between the two loads.
REQ-039 reset pulsed after 100 bytes of a load -> all outputs 0 next cycle; download held high afterward produces no cart_wr.
REQ-040 with CART_HEADER_CHECK_EN: image starting 67 20 47 43 45 -> hdr_ok=1, cart_valid=1; with byte 2 = 0x48 -> hdr_ok=0, cart_valid=0.
